// File: rtl/code_sequencer_if.sv
// code_sequencer_if: request/pulse bundle between a code sequencer and its user.
//   start, abort     : requester -> sequencer (start request, synchronous cancel)
//   busy             : sequence in progress
//   press1, press2   : button-1 / button-2 press pulses
//   done             : one-cycle pulse at the end of each completed pass
//   sym_idx[4:0]     : index of the symbol being sent, 0 when idle
interface code_sequencer_if;
   logic       start;
   logic       abort;
   logic       busy;
   logic       press1;
   logic       press2;
   logic       done;
   logic [4:0] sym_idx;

   modport master (
      output start, abort,
      input  busy, press1, press2, done, sym_idx
   );

   modport slave (
      input  start, abort,
      output busy, press1, press2, done, sym_idx
   );
endinterface

// File: rtl/code_sequencer.sv
// code_sequencer: keypad-code transmitter. On start it emits CODE_LEN press
// pulses (LSB of CODE first; 1 = press1, 0 = press2), each PULSE_CYCLES wide
// and followed by GAP_CYCLES of silence, then pulses done.
// Ports:
//   hwclk  : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : code_sequencer_if.slave (start/abort in; busy/press1/press2/done/sym_idx out)
// Optional feature: define CODE_SEQ_LOOP_EN to repeat the sequence until abort;
// done then pulses during the last gap cycle of every pass with busy held high.
module code_sequencer #(
   parameter int unsigned          CODE_LEN     = 4,
   parameter logic [CODE_LEN-1:0]  CODE         = 4'b1101,
   parameter int unsigned          PULSE_CYCLES = 12000,
   parameter int unsigned          GAP_CYCLES   = 1200000
) (
   input  logic              hwclk,
   input  logic              rst_n,
   code_sequencer_if.slave   bus
);

   localparam int unsigned MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int unsigned TMR_W      = $clog2(MAX_CYCLES + 1);
   localparam int unsigned IDX_W      = 5;

   localparam logic [31:0]      CODE_EXT   = 32'(CODE);
   localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYCLES - 1);
   localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(CODE_LEN - 1);
`ifdef CODE_SEQ_LOOP_EN
   // Timer value one cycle before the end of a gap (only meaningful when GAP_CYCLES >= 2)
   localparam logic [TMR_W-1:0] GAP_PRE    = TMR_W'(GAP_CYCLES - 2);
`endif

   typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

   state_t           state, state_nxt;
   logic [TMR_W-1:0] timer, timer_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [IDX_W-1:0] idx_inc;
   logic             busy_q, busy_nxt;
   logic             press1_q, press1_nxt;
   logic             press2_q, press2_nxt;
   logic             done_q, done_nxt;

   assign idx_inc = idx + IDX_W'(1);

   // State, counters and registered outputs
   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         timer    <= '0;
         idx      <= '0;
         busy_q   <= 1'b0;
         press1_q <= 1'b0;
         press2_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         timer    <= timer_nxt;
         idx      <= idx_nxt;
         busy_q   <= busy_nxt;
         press1_q <= press1_nxt;
         press2_q <= press2_nxt;
         done_q   <= done_nxt;
      end
   end

   // Next state and next output values; outputs are precomputed for the
   // upcoming cycle so that every output is a flop.
   always_comb begin
      state_nxt  = state;
      timer_nxt  = timer + TMR_W'(1);
      idx_nxt    = idx;
      busy_nxt   = 1'b0;
      press1_nxt = 1'b0;
      press2_nxt = 1'b0;
      done_nxt   = 1'b0;

      unique case (state)
         IDLE: begin
            timer_nxt = '0;
            idx_nxt   = '0;
            if (bus.start) begin
               state_nxt  = PULSE;
               busy_nxt   = 1'b1;
               press1_nxt = CODE_EXT[0];
               press2_nxt = ~CODE_EXT[0];
            end
         end

         PULSE: begin
            busy_nxt = 1'b1;
            if (timer == PULSE_LAST) begin
               state_nxt = GAP;
               timer_nxt = '0;
`ifdef CODE_SEQ_LOOP_EN
               if (GAP_CYCLES == 1 && idx == IDX_LAST) done_nxt = 1'b1;
`endif
            end else begin
               press1_nxt = CODE_EXT[idx];
               press2_nxt = ~CODE_EXT[idx];
            end
         end

         GAP: begin
            busy_nxt = 1'b1;
            if (timer == GAP_LAST) begin
               timer_nxt = '0;
               if (idx != IDX_LAST) begin
                  state_nxt  = PULSE;
                  idx_nxt    = idx_inc;
                  press1_nxt = CODE_EXT[idx_inc];
                  press2_nxt = ~CODE_EXT[idx_inc];
               end else begin
`ifdef CODE_SEQ_LOOP_EN
                  state_nxt  = PULSE;
                  idx_nxt    = '0;
                  press1_nxt = CODE_EXT[0];
                  press2_nxt = ~CODE_EXT[0];
`else
                  state_nxt  = IDLE;
                  idx_nxt    = '0;
                  busy_nxt   = 1'b0;
                  done_nxt   = 1'b1;
`endif
               end
            end else begin
`ifdef CODE_SEQ_LOOP_EN
               if (GAP_CYCLES >= 2 && timer == GAP_PRE && idx == IDX_LAST) done_nxt = 1'b1;
`endif
            end
         end

         default: begin
            state_nxt = IDLE;
            timer_nxt = '0;
            idx_nxt   = '0;
         end
      endcase

      // Cancel wins over everything, including a start seen in IDLE
      if (bus.abort) begin
         state_nxt  = IDLE;
         timer_nxt  = '0;
         idx_nxt    = '0;
         busy_nxt   = 1'b0;
         press1_nxt = 1'b0;
         press2_nxt = 1'b0;
         done_nxt   = 1'b0;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.press1  = press1_q;
   assign bus.press2  = press2_q;
   assign bus.done    = done_q;
   assign bus.sym_idx = idx;

endmodule

// File: tb/tb_code_sequencer.sv
// tb_code_sequencer: self-checking bench for code_sequencer (single-shot build),
// CODE_LEN=4, CODE=4'b1101, PULSE_CYCLES=3, GAP_CYCLES=2.
module tb_code_sequencer;

   localparam int unsigned LEN    = 4;
   localparam int unsigned P      = 3;
   localparam int unsigned G      = 2;
   localparam logic [3:0]  CODE_V = 4'b1101;
   localparam int          PERIOD = int'(P + G);
   localparam int          TOTAL  = int'(LEN) * PERIOD;

   typedef struct packed {
      logic       busy;
      logic       p1;
      logic       p2;
      logic       done;
      logic [4:0] idx;
   } outs_t;

   typedef struct {
      logic  st;
      outs_t exp;
   } vec_t;

   logic hwclk = 1'b0;
   logic rst_n;

   always #5 hwclk = ~hwclk;

   code_sequencer_if bus ();

   code_sequencer #(
      .CODE_LEN     (LEN),
      .CODE         (CODE_V),
      .PULSE_CYCLES (P),
      .GAP_CYCLES   (G)
   ) dut (
      .hwclk (hwclk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int    vectors    = 0;
   int    miscompares = 0;
   int    cyc        = 0;
   int    run_start  = -1;
   vec_t  tbl [22];
   int    done_cycles [$];

   function automatic outs_t mk(input logic b, input logic p1, input logic p2,
                                input logic d, input int idx);
      outs_t o;
      o.busy = b; o.p1 = p1; o.p2 = p2; o.done = d; o.idx = 5'(idx);
      return o;
   endfunction

   // Reference: a run accepted at run_start occupies TOTAL cycles; within it,
   // offset t selects symbol t/(P+G), and the first P cycles of each slot press.
   function automatic outs_t model_out(input int c);
      outs_t o;
      int t, k, r;
      o = '0;
      if (run_start >= 0) begin
         t = c - run_start;
         if (t >= 0 && t < TOTAL) begin
            k = t / PERIOD;
            r = t % PERIOD;
            o.busy = 1'b1;
            o.idx  = 5'(k);
            if (r < int'(P)) begin
               o.p1 = CODE_V[k];
               o.p2 = ~CODE_V[k];
            end
         end else if (t == TOTAL) begin
            o.done = 1'b1;
         end
      end
      return o;
   endfunction

   function automatic logic model_idle(input int c);
      return (run_start < 0) || ((c - run_start) >= TOTAL);
   endfunction

   function automatic outs_t dut_out();
      outs_t o;
      o.busy = bus.busy; o.p1 = bus.press1; o.p2 = bus.press2;
      o.done = bus.done; o.idx = bus.sym_idx;
      return o;
   endfunction

   task automatic check(input string name, input outs_t exp);
      outs_t act;
      act = dut_out();
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got busy=%b p1=%b p2=%b done=%b idx=%0d, expected busy=%b p1=%b p2=%b done=%b idx=%0d",
                  name, cyc, act.busy, act.p1, act.p2, act.done, act.idx,
                  exp.busy, exp.p1, exp.p2, exp.done, exp.idx);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive inputs for the current cycle, advance one edge, compare with the model
   task automatic tick(input logic s, input logic a);
      bus.start = s;
      bus.abort = a;
      @(posedge hwclk);
      cyc++;
      if (a) run_start = -1;
      else if (s && model_idle(cyc - 1)) run_start = cyc;
      #1;
      check("model", model_out(cyc));
      if (bus.done === 1'b1) done_cycles.push_back(cyc);
   endtask

   task automatic rebase();
      cyc       = 0;
      run_start = -1;
      done_cycles.delete();
   endtask

   initial begin
      // Entry i: start input during cycle i, expected outputs during cycle i+1
      tbl[0]  = '{1'b1, mk(1,1,0,0,0)};
      tbl[1]  = '{1'b0, mk(1,1,0,0,0)};
      tbl[2]  = '{1'b0, mk(1,1,0,0,0)};
      tbl[3]  = '{1'b0, mk(1,0,0,0,0)};
      tbl[4]  = '{1'b0, mk(1,0,0,0,0)};
      tbl[5]  = '{1'b0, mk(1,0,1,0,1)};
      tbl[6]  = '{1'b0, mk(1,0,1,0,1)};
      tbl[7]  = '{1'b0, mk(1,0,1,0,1)};
      tbl[8]  = '{1'b0, mk(1,0,0,0,1)};
      tbl[9]  = '{1'b0, mk(1,0,0,0,1)};
      tbl[10] = '{1'b0, mk(1,1,0,0,2)};
      tbl[11] = '{1'b0, mk(1,1,0,0,2)};
      tbl[12] = '{1'b0, mk(1,1,0,0,2)};
      tbl[13] = '{1'b0, mk(1,0,0,0,2)};
      tbl[14] = '{1'b0, mk(1,0,0,0,2)};
      tbl[15] = '{1'b0, mk(1,1,0,0,3)};
      tbl[16] = '{1'b0, mk(1,1,0,0,3)};
      tbl[17] = '{1'b0, mk(1,1,0,0,3)};
      tbl[18] = '{1'b0, mk(1,0,0,0,3)};
      tbl[19] = '{1'b0, mk(1,0,0,0,3)};
      tbl[20] = '{1'b0, mk(0,0,0,1,0)};
      tbl[21] = '{1'b0, mk(0,0,0,0,0)};

      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      #12;
      check("reset_state", '0);
      @(negedge hwclk);
      rst_n = 1'b1;

      // Basic pass, then the same with extra starts at cycles 5 and 12
      for (int pass = 0; pass < 2; pass++) begin
         rebase();
         for (int i = 0; i < 22; i++) begin
            tick(tbl[i].st | ((pass == 1) && (i == 5 || i == 12)), 1'b0);
            check(pass == 0 ? "basic" : "busy_protect", tbl[i].exp);
         end
         check_int(pass == 0 ? "basic_done_count" : "busy_protect_done_count",
                   done_cycles.size(), 1);
      end

      // Abort during the press2 pulse, restart at cycle 10
      rebase();
      for (int c = 0; c <= 32; c++) begin
         tick(c == 0 || c == 10, c == 7);
         if (cyc == 8) check("abort_clear", '0);
         if (cyc >= 11 && cyc <= 32) check("abort_restart", tbl[cyc - 11].exp);
      end
      check_int("abort_done_count", done_cycles.size(), 1);

      // Back-to-back with start held high
      rebase();
      for (int c = 0; c < 50; c++) tick(c < 42, 1'b0);
      check_int("b2b_done_count", done_cycles.size(), 2);
      if (done_cycles.size() >= 2) begin
         check_int("b2b_first_done", done_cycles[0], 21);
         check_int("b2b_second_done", done_cycles[1], 42);
      end

      // Randomised start/abort traffic against the model
      rebase();
      for (int c = 0; c < 3000; c++)
         tick($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
      tick(1'b0, 1'b1);

      // Asynchronous reset in the middle of a pulse
      rebase();
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      check("pre_reset_pulse", mk(1,1,0,0,0));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", '0);
      run_start = -1;
      repeat (2) @(posedge hwclk);
      @(negedge hwclk);
      rst_n = 1'b1;
      rebase();
      for (int c = 0; c < 6; c++) tick(1'b0, 1'b0);
      check("post_reset_idle", '0);
      for (int c = 0; c < 24; c++) tick(c == 0, 1'b0);
      check_int("post_reset_done_count", done_cycles.size(), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
